// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Optional burst locking is enabled with FIFO_ARB_LOCK_EN.
package fifo_arb_pkg;

    typedef enum logic {ARB_IDLE, ARB_LOCK} arb_state_t;

    function automatic int id_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
// Part of fifo_wr_arbiter; FIFO_ARB_LOCK_EN does not affect this block.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any
);

    logic [2*NUM_REQ-1:0] dbl;
    logic                 found;

    assign dbl = {req, req};
    assign any = |req;

    // Bits below ptr are masked off; the upper copy supplies the wrapped candidates.
    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        for (int unsigned i = 0; i < 2 * NUM_REQ; i++) begin
            if (!found && (i >= int'(ptr)) && dbl[i]) begin
                found   = 1'b1;
                gnt_idx = ID_W'(i % NUM_REQ);
            end
        end
        gnt_onehot = any ? (NUM_REQ'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port through a single-beat holding register.
// Define FIFO_ARB_LOCK_EN to add req_last and hold the grant for a whole burst.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int WIDTH   = 8,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       req_ready,
`ifdef FIFO_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       req_last,
`endif
    input  logic                     fifo_ready,
    output logic                     fifo_wr_en,
    output logic [WIDTH-1:0]         fifo_data,
    output logic [ID_W-1:0]          fifo_src_id
);

    arb_state_t         state;
    logic [ID_W-1:0]    ptr;
    logic               out_vld;
    logic [WIDTH-1:0]   out_data;
    logic [ID_W-1:0]    out_id;

    logic [NUM_REQ-1:0] cand;
    logic [NUM_REQ-1:0] gnt_onehot;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    ptr_next;
    logic               any;
    logic               load;
    logic               accept;
    logic               last_g;

`ifdef FIFO_ARB_LOCK_EN
    logic [ID_W-1:0]    owner;

    // While locked only the burst owner may compete; ptr is left untouched.
    assign cand   = (state == ARB_LOCK) ? (req_valid & (NUM_REQ'(1) << owner)) : req_valid;
    assign last_g = req_last[gnt_idx];
`else
    assign cand   = req_valid;
    assign last_g = 1'b1;
`endif

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req        (cand),
        .ptr        (ptr),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any)
    );

    assign load      = ~out_vld | fifo_ready;
    assign req_ready = (load && any && !rst) ? gnt_onehot : '0;
    assign accept    = |req_ready;
    assign ptr_next  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    assign fifo_wr_en  = out_vld & fifo_ready & ~rst;
    assign fifo_data   = out_data;
    assign fifo_src_id = out_id;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_id   <= '0;
            ptr      <= '0;
            state    <= ARB_IDLE;
`ifdef FIFO_ARB_LOCK_EN
            owner    <= '0;
`endif
        end else if (accept) begin
            out_vld  <= 1'b1;
            out_data <= req_data[gnt_idx*WIDTH +: WIDTH];
            out_id   <= gnt_idx;
            if (state == ARB_IDLE || last_g)
                ptr <= ptr_next;
`ifdef FIFO_ARB_LOCK_EN
            if (state == ARB_IDLE && !last_g) begin
                state <= ARB_LOCK;
                owner <= gnt_idx;
            end else if (state == ARB_LOCK && last_g) begin
                state <= ARB_IDLE;
            end
`endif
        end else if (fifo_ready) begin
            out_vld <= 1'b0;
        end
    end

endmodule
